// File: rtl/pgm_gfx_ddram_responder.sv
// pgm_gfx_ddram_responder
// Serves 64-bit graphics-ROM word reads for the PGM video engines from a
// single-line burst buffer. Misses are refilled with one BURST-long read on
// the MiSTer DDRAM Avalon-MM port. Sequential fetches within the buffered
// line complete without touching DDRAM.
module pgm_gfx_ddram_responder #(
    parameter int          BURST     = 4,
    parameter logic [28:0] BASE_ADDR = 29'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,

    // Client side
    input  logic        req_rd,
    input  logic [28:0] req_addr,
    output logic        req_busy,
    output logic [63:0] req_dout,
    output logic        req_dout_ready,

    // Line buffer invalidate (ROM reload)
    input  logic        inv,

    // DDRAM Avalon-MM side
    output logic        mem_rd,
    output logic [28:0] mem_addr,
    output logic [7:0]  mem_burstcnt,
    input  logic        mem_busy,
    input  logic [63:0] mem_dout,
    input  logic        mem_dout_ready
);

    // Number of word-select bits inside one line.
    localparam int WB = $clog2(BURST);
    localparam int TW = 29 - WB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ISSUE,
        S_RECV,
        S_RESP,
        S_HOLD
    } state_t;

    state_t          state;
    logic [28:0]     addr_q;      // client address latched at acceptance
    logic [TW-1:0]   tag;         // line address (upper bits) held in the buffer
    logic            valid;       // buffer contents match tag
    logic            inv_seen;    // invalidate arrived while a fill was in flight
    logic [WB-1:0]   beat;        // next buffer slot to write during a fill
    logic [63:0]     line_buf [BURST];

    logic [TW-1:0]   addr_line;
    logic [WB-1:0]   addr_word;
    logic [28:0]     line_base;
    logic            hit;

    assign addr_line    = addr_q[28:WB];
    assign addr_word    = addr_q[WB-1:0];
    assign line_base    = {addr_line, {WB{1'b0}}};
    // An invalidate in the lookup cycle wins over a matching tag.
    assign hit          = valid && !inv && (tag == addr_line);
    assign mem_burstcnt = 8'(BURST);

    // Request sequencing: accept, look up, refill on miss, respond, hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            req_busy       <= 1'b0;
            req_dout_ready <= 1'b0;
            req_dout       <= '0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            valid          <= 1'b0;
            inv_seen       <= 1'b0;
            beat           <= '0;
        end else begin
            req_dout_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inv) begin
                        valid <= 1'b0;
                    end
                    if (req_rd) begin
                        addr_q   <= req_addr;
                        req_busy <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (inv) begin
                        valid <= 1'b0;
                    end
                    if (hit) begin
                        state <= S_RESP;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= BASE_ADDR + line_base;
                        inv_seen <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (inv) begin
                        inv_seen <= 1'b1;
                    end
                    // Address and read stay put until waitrequest drops.
                    if (!mem_busy) begin
                        mem_rd <= 1'b0;
                        beat   <= '0;
                        valid  <= 1'b0;
                        state  <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (inv) begin
                        inv_seen <= 1'b1;
                    end
                    if (mem_dout_ready) begin
                        beat <= beat + 1'b1;
                        if (beat == WB'(BURST - 1)) begin
                            tag   <= addr_line;
                            valid <= !(inv_seen || inv);
                            state <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (inv) begin
                        valid <= 1'b0;
                    end
                    req_dout       <= line_buf[addr_word];
                    req_dout_ready <= 1'b1;
                    state          <= S_HOLD;
                end

                S_HOLD: begin
                    if (inv) begin
                        valid <= 1'b0;
                    end
                    req_busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    req_busy <= 1'b0;
                    mem_rd   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffer fill; beats seen outside a fill are dropped.
    always_ff @(posedge clk) begin
        if (state == S_RECV && mem_dout_ready) begin
            line_buf[beat] <= mem_dout;
        end
    end

endmodule
